// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, a word FIFO feeding an LSB-first serialiser.
// Optional runtime parity is compiled in when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for a word in the FIFO
// START  | start bit (low), one bit time
// DATA   | DATA_BITS data bits, LSB first
// PARITY | parity bit from the latched config (parity builds only)
// STOP   | STOP_BITS high bit times, then pop back-to-back or return to IDLE
module uart_tx_fifo #(
  parameter int CLOCK_DIVIDER = 417,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_en,
  input  logic                          parity_odd,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLOCK_DIVIDER);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          baud_cnt, baud_d;
  logic [3:0]             bit_cnt, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_d;
  logic                   tick, push, pop;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic                   par_en_q, par_bit_q;

  assign wr_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign busy     = (state != IDLE) || (fifo_level != '0);
  assign tick     = (baud_cnt == CW'(CLOCK_DIVIDER - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity config and bit are frozen at the pop so mid-frame input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      par_en_q  <= parity_en;
      par_bit_q <= (^mem[rd_ptr]) ^ parity_odd;
    end
  end
`else
  assign par_en_q  = 1'b0;
  assign par_bit_q = 1'b0;
`endif

  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state)
      IDLE:   if (fifo_level != '0) pop = 1'b1;
      START:  if (tick) begin
                state_d = DATA;
                bit_d   = '0;
              end
      DATA:   if (tick) begin
                if (bit_cnt == 4'(DATA_BITS - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
                  bit_d   = '0;
                end else begin
                  bit_d   = bit_cnt + 4'd1;
                  shift_d = shift_q >> 1;
                end
              end
      PARITY: if (tick) begin
                state_d = STOP;
                bit_d   = '0;
              end
      STOP:   if (tick) begin
                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                  if (fifo_level != '0) pop = 1'b1;
                  else                  state_d = IDLE;
                end else begin
                  bit_d = bit_cnt + 4'd1;
                end
              end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      shift_d = mem[rd_ptr];
      bit_d   = '0;
    end
    baud_d = (state_d == IDLE || tick || pop) ? '0 : baud_cnt + CW'(1);
    // tx is registered from the state being entered, so it changes on the same edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random and directed stimulus for uart_tx_fifo, checked against a
// frame-schedule model (queue of words plus start/end times of the frame on the line).
module tb_uart_tx_fifo;

  localparam int CD = 4;
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
`ifdef UART_TX_PARITY_EN
  logic       parity_en;
  logic       parity_odd;
`endif

  logic [4:0] wr_data2;
  logic       wr_valid2;
  logic       wr_ready2;
  logic       tx2;
  logic       busy2;
  logic [2:0] fifo_level2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLOCK_DIVIDER(CD), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
`ifdef UART_TX_PARITY_EN
    .parity_en(parity_en), .parity_odd(parity_odd),
`endif
    .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_fifo #(.CLOCK_DIVIDER(CD), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(FD)) dut2 (
    .clk(clk), .rst(rst), .wr_data(wr_data2), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
`ifdef UART_TX_PARITY_EN
    .parity_en(1'b0), .parity_odd(1'b0),
`endif
    .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // reference model state
  logic [7:0] q[$];
  int         e       = 0;
  int         f_start = 0;
  int         f_end   = 0;
  logic [7:0] cur_word;
  logic       m_par_en  = 1'b0;
  logic       m_par_odd = 1'b0;
  int         falls[$];
  logic       tx_prev = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic exp_bit(input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return cur_word[idx-1];
    if (idx == DB + 1 && m_par_en) return (^cur_word) ^ m_par_odd;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d);
    logic ready_pre;
    ready_pre = (q.size() != FD);
    e++;
    if (e >= f_end && q.size() != 0) begin
      cur_word = q.pop_front();
`ifdef UART_TX_PARITY_EN
      m_par_en  = parity_en;
      m_par_odd = parity_odd;
`else
      m_par_en  = 1'b0;
      m_par_odd = 1'b0;
`endif
      f_start = e;
      f_end   = e + (1 + DB + (m_par_en ? 1 : 0) + SB) * CD;
    end
    if (v && ready_pre) q.push_back(d);
  endtask

  task automatic check_all();
    logic exp_tx;
    exp_tx = (e >= f_start && e < f_end) ? exp_bit((e - f_start) / CD) : 1'b1;
    check_eq("tx", tx, exp_tx);
    check_eq("fifo_level", fifo_level, q.size());
    check_eq("wr_ready", wr_ready, q.size() != FD);
    check_eq("busy", busy, (e < f_end) || (q.size() != 0));
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    wr_valid = v;
    wr_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    check_all();
    if (tx_prev === 1'b1 && tx === 1'b0) falls.push_back(e);
    tx_prev = tx;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    #1;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_ready", wr_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    e       = 0;
    f_start = 0;
    f_end   = 0;
    tx_prev = 1'b1;
  endtask

  // k = 0 is the pop edge; samples each bit mid-way and checks the exact frame end.
  task automatic frame_check(input string tag, input int nbits, input logic use2,
                             input logic [15:0] exp_seq);
    logic [15:0] seq;
    seq = '0;
    for (int k = 0; k <= nbits * CD; k++) begin
      cycle(1'b0, 8'h00);
      if (k % CD == 2) seq[k / CD] = use2 ? tx2 : tx;
      if (k == nbits * CD - 1) check_eq({tag, "_busy_end"}, use2 ? busy2 : busy, 1'b1);
`ifdef UART_TX_PARITY_EN
      if (k == 10) parity_odd = ~parity_odd;
`endif
    end
    check_eq({tag, "_bits"}, seq, exp_seq);
    check_eq({tag, "_idle"}, use2 ? busy2 : busy, 1'b0);
    check_eq({tag, "_line"}, use2 ? tx2 : tx, 1'b1);
  endtask

  initial begin
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_valid2 = 1'b0;
    wr_data2  = '0;
`ifdef UART_TX_PARITY_EN
    parity_en  = 1'b0;
    parity_odd = 1'b0;
`endif
    #2 do_reset();

    // single byte written at edge 10
    for (int k = 0; k < 9; k++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hA5);
    frame_check("a5", 10, 1'b0, 16'h034A);

    // back-to-back frames
    falls.delete();
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    for (int k = 0; k < 90; k++) cycle(1'b0, 8'h00);
    check_eq("b2b_starts", falls.size(), 2);
    if (falls.size() == 2) check_eq("b2b_gap", falls[1] - falls[0], 40);

    // burst past full
    for (int k = 0; k < 6; k++) cycle(1'b1, 8'($urandom));
    for (int k = 0; k < 260; k++) cycle(1'b0, 8'h00);

`ifdef UART_TX_PARITY_EN
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    cycle(1'b1, 8'h07);
    frame_check("par07", 11, 1'b0, 16'h060E);
    parity_en  = 1'b0;
    parity_odd = 1'b0;
`endif

    // reset during DATA with three words queued behind the frame in flight
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'h00);
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00);
    check_eq("mid_tx_low", tx, 1'b0);
    check_eq("mid_level", fifo_level, 3);
    do_reset();
    for (int k = 0; k < 100; k++) cycle(1'b0, 8'h00);

    // randomized traffic at several write densities
    for (int p = 0; p < 3; p++) begin
      int pct;
      pct = (p == 0) ? 90 : (p == 1) ? 40 : 8;
      for (int k = 0; k < 300; k++) begin
`ifdef UART_TX_PARITY_EN
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
`endif
        cycle(1'($urandom_range(0, 99) < pct), 8'($urandom));
      end
    end
    for (int k = 0; k < 260; k++) cycle(1'b0, 8'h00);

    // 5 data bits, 2 stop bits
    wr_valid2 = 1'b1;
    wr_data2  = 5'h1F;
    cycle(1'b0, 8'h00);
    wr_valid2 = 1'b0;
    frame_check("db5sb2", 8, 1'b1, 16'h00FE);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
